// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared widths, address field indices and responder FSM encoding
package cache_pkg;
    localparam int CP_WORD_WIDTH = 32;
    localparam int CP_ADR_WIDTH  = 32;
    localparam int LINE_WORDS    = 4;
    localparam int ADR_WORD_LSB  = 2;
    localparam int ADR_TAG_LSB   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_DONE = 2'd3
    } mem_state_e;
endpackage

// File: rtl/mem_sp_ram.sv
// rtl/mem_sp_ram.sv - one write port, one registered write-first read port
module mem_sp_ram #(
    parameter int DW = 32,
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic          re,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] rd
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
    end

    // Read register holds its value until the next read; a colliding write wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd <= '0;
        end else if (re) begin
            rd <= (we && (wa == ra)) ? wd : mem[ra];
        end
    end
endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - backing memory for cache misses; optional MEM_STATS_EN counters
module mem_responder
    import cache_pkg::*;
#(
    parameter int WORD_WIDTH    = CP_WORD_WIDTH,
    parameter int ADR_WIDTH     = CP_ADR_WIDTH,
    parameter int MEM_WORDS     = 4096,
    parameter int BURST_LEN     = LINE_WORDS,
    parameter int FIRST_LATENCY = 4,
    parameter int BEAT_LATENCY  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_req_i,
    input  logic [ADR_WIDTH-1:0]  mem_adr_i,
    output logic                  mem_ack_o,
    output logic [WORD_WIDTH-1:0] mem_dat_o,
    input  logic                  wb_valid_i,
    input  logic [ADR_WIDTH-1:0]  wb_adr_i,
    input  logic [1:0]            wb_word_i,
    input  logic [WORD_WIDTH-1:0] wb_dat_i,
`ifdef MEM_STATS_EN
    output logic [31:0]           stat_rd_o,
    output logic [31:0]           stat_wb_o,
`endif
    output logic                  busy_o
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int TW = ADR_WIDTH - ADR_TAG_LSB;

    mem_state_e    state, state_nx;
    logic [7:0]    lat_cnt, lat_nx;
    logic [7:0]    beat_cnt, beat_nx;
    logic [TW-1:0] tag_q, tag_nx;
    logic          rd_fire;
    logic          wb_we;
    logic [TW-1:0] cur_tag;

    assign cur_tag = mem_adr_i[ADR_WIDTH-1:ADR_TAG_LSB];
    assign wb_we   = wb_valid_i & ~rst;

    logic unused_adr_bits;
    assign unused_adr_bits = ^{mem_adr_i[1:0], wb_adr_i[ADR_WIDTH-1:AW+2], wb_adr_i[3:0]};

    mem_sp_ram #(.DW(WORD_WIDTH), .AW(AW)) u_ram (
        .clk (clk),
        .rst (rst),
        .we  (wb_we),
        .wa  ({wb_adr_i[AW+1:ADR_TAG_LSB], wb_word_i}),
        .wd  (wb_dat_i),
        .re  (rd_fire),
        .ra  (mem_adr_i[AW+1:ADR_WORD_LSB]),
        .rd  (mem_dat_o)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            lat_cnt  <= '0;
            beat_cnt <= '0;
            tag_q    <= '0;
        end else begin
            state    <= state_nx;
            lat_cnt  <= lat_nx;
            beat_cnt <= beat_nx;
            tag_q    <= tag_nx;
        end
    end

    // The read for the next ack is launched one cycle ahead, so with unit beat
    // latency the ACK state re-fires itself instead of passing through WAIT.
    always_comb begin
        state_nx = state;
        lat_nx   = lat_cnt;
        beat_nx  = beat_cnt;
        tag_nx   = tag_q;
        rd_fire  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mem_req_i) begin
                    state_nx = ST_WAIT;
                    lat_nx   = 8'(FIRST_LATENCY - 1);
                    beat_nx  = '0;
                    tag_nx   = cur_tag;
                end
            end
            ST_WAIT: begin
                if (!mem_req_i) begin
                    state_nx = ST_IDLE;
                end else if (lat_cnt == 8'd0) begin
                    rd_fire  = 1'b1;
                    state_nx = ST_ACK;
                end else begin
                    lat_nx = lat_cnt - 8'd1;
                end
            end
            ST_ACK: begin
                if (!mem_req_i) begin
                    state_nx = ST_IDLE;
                end else if (beat_cnt == 8'(BURST_LEN - 1)) begin
                    state_nx = ST_DONE;
                end else begin
                    beat_nx = beat_cnt + 8'd1;
                    if (BEAT_LATENCY == 1) begin
                        rd_fire = 1'b1;
                    end else begin
                        lat_nx   = 8'(BEAT_LATENCY - 2);
                        state_nx = ST_WAIT;
                    end
                end
            end
            ST_DONE: begin
                if (!mem_req_i) begin
                    state_nx = ST_IDLE;
                end else if (cur_tag != tag_q) begin
                    state_nx = ST_WAIT;
                    lat_nx   = 8'(FIRST_LATENCY - 1);
                    beat_nx  = '0;
                    tag_nx   = cur_tag;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign mem_ack_o = (state == ST_ACK);
    assign busy_o    = (state != ST_IDLE);

`ifdef MEM_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_rd_o <= '0;
            stat_wb_o <= '0;
        end else begin
            if (mem_ack_o && (stat_rd_o != 32'hFFFF_FFFF)) begin
                stat_rd_o <= stat_rd_o + 32'd1;
            end
            if (wb_valid_i && (stat_wb_o != 32'hFFFF_FFFF)) begin
                stat_wb_o <= stat_wb_o + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed table-driven bench for mem_responder
module tb_mem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req_i;
    logic [31:0] mem_adr_i;
    logic        mem_ack_o;
    logic [31:0] mem_dat_o;
    logic        wb_valid_i;
    logic [31:0] wb_adr_i;
    logic [1:0]  wb_word_i;
    logic [31:0] wb_dat_i;
    logic        busy_o;
`ifdef MEM_STATS_EN
    logic [31:0] stat_rd_o;
    logic [31:0] stat_wb_o;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    mem_responder dut (
        .clk        (clk),
        .rst        (rst),
        .mem_req_i  (mem_req_i),
        .mem_adr_i  (mem_adr_i),
        .mem_ack_o  (mem_ack_o),
        .mem_dat_o  (mem_dat_o),
        .wb_valid_i (wb_valid_i),
        .wb_adr_i   (wb_adr_i),
        .wb_word_i  (wb_word_i),
        .wb_dat_i   (wb_dat_i),
`ifdef MEM_STATS_EN
        .stat_rd_o  (stat_rd_o),
        .stat_wb_o  (stat_wb_o),
`endif
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]       adr;
        logic [3:0][31:0]  exp;
        int                wb_beat;
        logic [31:0]       wb_dat;
        bit                hold;
    } vec_t;

    vec_t tbl [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [1:0] w, input logic [31:0] dat);
        wb_valid_i = 1'b1;
        wb_adr_i   = adr;
        wb_word_i  = w;
        wb_dat_i   = dat;
        tick();
        wb_valid_i = 1'b0;
    endtask

    // Plays the cache side: presents the next wrapped word address as soon as an ack is seen.
    task automatic run_burst(input int idx);
        int          n;
        logic [31:0] nxt;
        mem_req_i = 1'b1;
        mem_adr_i = tbl[idx].adr;
        n = 0;
        do begin
            tick();
            n++;
        end while (!mem_ack_o && n < 20);
        check($sformatf("v%0d_first_lat", idx), n, 5);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("v%0d_dat%0d", idx, k), mem_dat_o, tbl[idx].exp[k]);
            if (k < 3) begin
                nxt = {mem_adr_i[31:4], mem_adr_i[3:2] + 2'd1, 2'b00};
                mem_adr_i = nxt;
                if (k + 1 == tbl[idx].wb_beat) begin
                    wb_valid_i = 1'b1;
                    wb_adr_i   = {nxt[31:4], 4'h0};
                    wb_word_i  = nxt[3:2];
                    wb_dat_i   = tbl[idx].wb_dat;
                end
                tick();
                wb_valid_i = 1'b0;
                check($sformatf("v%0d_ack%0d", idx, k + 1), 32'(mem_ack_o), 32'd1);
            end
        end
        for (int d = 0; d < 2; d++) begin
            tick();
            check($sformatf("v%0d_done_noack%0d", idx, d), 32'(mem_ack_o), 32'd0);
            check($sformatf("v%0d_done_busy%0d", idx, d), 32'(busy_o), 32'd1);
        end
        if (!tbl[idx].hold) begin
            mem_req_i = 1'b0;
            tick();
            check($sformatf("v%0d_idle_busy", idx), 32'(busy_o), 32'd0);
        end
    endtask

    initial begin
        logic any_ack;
        int   n;

        tbl[0] = '{adr: 32'h100, exp: {32'h43, 32'h42, 32'h41, 32'h40}, wb_beat: -1, wb_dat: 32'h0, hold: 1'b1};
        tbl[1] = '{adr: 32'h200, exp: {32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001, 32'hDEAD0000},
                   wb_beat: -1, wb_dat: 32'h0, hold: 1'b0};
        tbl[2] = '{adr: 32'h108, exp: {32'h41, 32'h40, 32'h43, 32'h42}, wb_beat: -1, wb_dat: 32'h0, hold: 1'b0};
        tbl[3] = '{adr: 32'h10C, exp: {32'h42, 32'h41, 32'h40, 32'h43}, wb_beat: -1, wb_dat: 32'h0, hold: 1'b0};
        tbl[4] = '{adr: 32'h100, exp: {32'h43, 32'h42, 32'h5A5A0041, 32'h40},
                   wb_beat: 1, wb_dat: 32'h5A5A0041, hold: 1'b0};
        tbl[5] = '{adr: 32'h300, exp: {32'hC3, 32'hC2, 32'hC1, 32'hC0}, wb_beat: -1, wb_dat: 32'h0, hold: 1'b0};

        rst = 1'b1;
        mem_req_i = 1'b0;
        mem_adr_i = '0;
        wb_valid_i = 1'b0;
        wb_adr_i = '0;
        wb_word_i = '0;
        wb_dat_i = '0;
        repeat (3) tick();
        check("rst_ack", 32'(mem_ack_o), 32'd0);
        check("rst_dat", mem_dat_o, 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        rst = 1'b0;

        for (int w = 0; w < 4; w++) begin
            wb_write(32'h100, 2'(w), 32'h40 + 32'(w));
            wb_write(32'h200, 2'(w), 32'hDEAD0000 + 32'(w));
            wb_write(32'h300, 2'(w), 32'hC0 + 32'(w));
        end

        for (int i = 0; i < 5; i++) run_burst(i);

        // Request dropped while waiting: no ack ever.
        mem_req_i = 1'b1;
        mem_adr_i = 32'h100;
        tick();
        tick();
        mem_req_i = 1'b0;
        any_ack = 1'b0;
        tick();
        check("abort_wait_busy", 32'(busy_o), 32'd0);
        repeat (6) begin
            any_ack |= mem_ack_o;
            tick();
        end
        check("abort_wait_noack", 32'(any_ack), 32'd0);

        // Request dropped after the first ack: no further acks.
        mem_req_i = 1'b1;
        mem_adr_i = 32'h100;
        n = 0;
        do begin
            tick();
            n++;
        end while (!mem_ack_o && n < 20);
        check("abort_ack_first", 32'(mem_ack_o), 32'd1);
        mem_req_i = 1'b0;
        mem_adr_i = 32'h104;
        any_ack = 1'b0;
        tick();
        check("abort_ack_busy", 32'(busy_o), 32'd0);
        repeat (6) begin
            any_ack |= mem_ack_o;
            tick();
        end
        check("abort_ack_noack", 32'(any_ack), 32'd0);

        // Reset during WAIT, with a write-back on the reset cycle that must be dropped.
        mem_req_i = 1'b1;
        mem_adr_i = 32'h300;
        tick();
        tick();
        rst = 1'b1;
        wb_valid_i = 1'b1;
        wb_adr_i = 32'h300;
        wb_word_i = 2'd0;
        wb_dat_i = 32'h00000BAD;
        tick();
        check("midrst_ack", 32'(mem_ack_o), 32'd0);
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_dat", mem_dat_o, 32'd0);
        rst = 1'b0;
        wb_valid_i = 1'b0;
        mem_req_i = 1'b0;
        tick();
        check("midrst_idle", 32'(busy_o), 32'd0);
        run_burst(5);

`ifdef MEM_STATS_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("stat_rst_rd", stat_rd_o, 32'd0);
        check("stat_rst_wb", stat_wb_o, 32'd0);
        for (int w = 0; w < 4; w++) wb_write(32'h200, 2'(w), 32'hDEAD0000 + 32'(w));
        run_burst(1);
        run_burst(1);
        check("stat_rd", stat_rd_o, 32'd8);
        check("stat_wb", stat_wb_o, 32'd4);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
